ysyx_25020047_wbu_stage: RTL and testbench

YSYX_25020047_WBU_STAGE -- requirements
Module: ysyx_25020047_wbu_stage

---
 rtl/ysyx_25020047_wbu_stage.sv | 125 ++++++++++++
 tb/tb_ysyx_25020047_wbu_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_wbu_stage.sv
// Writeback stage: captures a retiring instruction, waits for load data if needed,
// and holds the registered commit (rd/wdata/dnpc) until downstream accepts it.
module ysyx_25020047_wbu_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RD_W  = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_wb_sel,
   input  logic [1:0]       in_pc_sel,
   input  logic [2:0]       in_ld_fmt,
   input  logic [RD_W-1:0]  in_rd,
   input  logic [XLEN-1:0]  in_result,
   input  logic [XLEN-1:0]  in_snpc,
   input  logic [XLEN-1:0]  in_csr_rdata,
   input  logic [XLEN-1:0]  in_mtvec,
   input  logic [1:0]       in_addr_lo,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_wen,
   output logic [RD_W-1:0]  out_rd,
   output logic [XLEN-1:0]  out_wdata,
   output logic [XLEN-1:0]  out_dnpc,
   output logic [CNT_W-1:0] commit_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD} state_t;

   state_t          state, state_nxt;
   logic            accept, commit, is_load;
   logic            wen_c;
   logic [XLEN-1:0] wdata_c, dnpc_c;
   logic [2:0]      ld_fmt_q;
   logic [1:0]      addr_lo_q;

   function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] fmt,
                                                input logic [1:0] lo,
                                                input logic [XLEN-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lo, 3'b000} +: 8];
      h = w[{lo[1], 4'b0000} +: 16];
      case (fmt)
         3'd0:    fmt_load = {{(XLEN-8){b[7]}}, b};
         3'd1:    fmt_load = {{(XLEN-16){h[15]}}, h};
         3'd4:    fmt_load = {{(XLEN-8){1'b0}}, b};
         3'd5:    fmt_load = {{(XLEN-16){1'b0}}, h};
         default: fmt_load = w;
      endcase
   endfunction

   assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign commit    = (state == HOLD) && out_ready;
   assign out_valid = (state == HOLD);
   assign is_load   = (in_wb_sel == 3'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = is_load ? WAIT_MEM : HOLD;
         WAIT_MEM: if (mem_rvalid) state_nxt = HOLD;
         HOLD: begin
            if (out_ready) begin
               if (accept) state_nxt = is_load ? WAIT_MEM : HOLD;
               else        state_nxt = IDLE;
            end
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // Load writeback data is filled in later from mem_rdata; everything else is known at accept.
   always_comb begin
      wen_c   = (in_wb_sel >= 3'd1) && (in_wb_sel <= 3'd4) && (in_rd != '0);
      wdata_c = '0;
      case (in_wb_sel)
         3'd1:    wdata_c = in_result;
         3'd2:    wdata_c = in_snpc;
         3'd4:    wdata_c = in_csr_rdata;
         default: wdata_c = '0;
      endcase
      dnpc_c = in_snpc;
      case (in_pc_sel)
         2'd1:    dnpc_c = in_result;
         2'd2:    dnpc_c = in_mtvec;
         default: dnpc_c = in_snpc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_wen    <= 1'b0;
         out_rd     <= '0;
         out_wdata  <= '0;
         out_dnpc   <= '0;
         ld_fmt_q   <= '0;
         addr_lo_q  <= '0;
         commit_cnt <= '0;
      end else begin
         if (accept) begin
            out_wen   <= wen_c;
            out_rd    <= in_rd;
            out_wdata <= wdata_c;
            out_dnpc  <= dnpc_c;
            ld_fmt_q  <= in_ld_fmt;
            addr_lo_q <= in_addr_lo;
         end else if ((state == WAIT_MEM) && mem_rvalid) begin
            out_wdata <= fmt_load(ld_fmt_q, addr_lo_q, mem_rdata);
         end
         if (commit) commit_cnt <= commit_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_wbu_stage.sv
// Directed bench for the writeback stage: ALU/load/jal/ecall commits, backpressure,
// back-to-back flow, async reset mid-load, and commit counter wrap on a narrow instance.
module tb_ysyx_25020047_wbu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  in_wb_sel, in_ld_fmt;
   logic [1:0]  in_pc_sel, in_addr_lo;
   logic [4:0]  in_rd;
   logic [31:0] in_result, in_snpc, in_csr_rdata, in_mtvec;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        out_valid, out_ready, out_wen;
   logic [4:0]  out_rd;
   logic [31:0] out_wdata, out_dnpc, commit_cnt;

   logic        w_in_ready, w_out_valid, w_out_wen;
   logic [4:0]  w_out_rd;
   logic [31:0] w_out_wdata, w_out_dnpc;
   logic [1:0]  w_commit_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned exp_cnt  = 0;

   always #5 clk = ~clk;

   ysyx_25020047_wbu_stage #(.XLEN(32), .RD_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_wb_sel(in_wb_sel), .in_pc_sel(in_pc_sel), .in_ld_fmt(in_ld_fmt), .in_rd(in_rd),
      .in_result(in_result), .in_snpc(in_snpc), .in_csr_rdata(in_csr_rdata),
      .in_mtvec(in_mtvec), .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_wen(out_wen), .out_rd(out_rd), .out_wdata(out_wdata), .out_dnpc(out_dnpc),
      .commit_cnt(commit_cnt)
   );

   ysyx_25020047_wbu_stage #(.XLEN(32), .RD_W(5), .CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_wb_sel(in_wb_sel), .in_pc_sel(in_pc_sel), .in_ld_fmt(in_ld_fmt), .in_rd(in_rd),
      .in_result(in_result), .in_snpc(in_snpc), .in_csr_rdata(in_csr_rdata),
      .in_mtvec(in_mtvec), .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .out_valid(w_out_valid), .out_ready(out_ready),
      .out_wen(w_out_wen), .out_rd(w_out_rd), .out_wdata(w_out_wdata),
      .out_dnpc(w_out_dnpc), .commit_cnt(w_commit_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load vectors: format, address low bits, raw word, expected writeback
   logic [2:0]  ld_fmt_v [9] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd0, 3'd0, 3'd7};
   logic [1:0]  ld_lo_v  [9] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd3};
   logic [31:0] ld_raw_v [9] = '{32'h0080FF00, 32'h0080FF00, 32'h0080FF00, 32'h0080FF00,
                                 32'h0080FF00, 32'h80010000, 32'h0080FF00, 32'h9A000000,
                                 32'h12345678};
   logic [31:0] ld_exp_v [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF00, 32'h0000FF00,
                                 32'h0080FF00, 32'hFFFF8001, 32'hFFFFFFFF, 32'hFFFFFF9A,
                                 32'h12345678};

   // Back-to-back vectors with hand-computed results
   // result=0x100+i, snpc=0x200+4i, csr=0x300+i, mtvec=0x400
   logic [2:0]  bb_wb_v   [8] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd5};
   logic [1:0]  bb_pc_v   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
   logic        bb_wen_v  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [31:0] bb_wd_v   [8] = '{32'h100, 32'h204, 32'h302, 32'h103,
                                  32'h210, 32'h305, 32'h0,   32'h0};
   logic [31:0] bb_dnpc_v [8] = '{32'h200, 32'h101, 32'h400, 32'h20C,
                                  32'h210, 32'h105, 32'h400, 32'h21C};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_wb_sel = '0; in_pc_sel = '0; in_ld_fmt = '0;
      in_rd = '0; in_result = '0; in_snpc = '0; in_csr_rdata = '0; in_mtvec = '0;
      in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_wen", out_wen, 0);
      check("rst_rd", out_rd, 0);
      check("rst_wdata", out_wdata, 0);
      check("rst_dnpc", out_dnpc, 0);
      check("rst_cnt", commit_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();

      // addi
      in_valid = 1'b1; in_wb_sel = 3'd1; in_pc_sel = 2'd0; in_rd = 5'd5;
      in_result = 32'h12; in_snpc = 32'h80000004;
      tick();
      in_valid = 1'b0;
      check("addi_valid", out_valid, 1);
      check("addi_wen", out_wen, 1);
      check("addi_rd", out_rd, 5);
      check("addi_wdata", out_wdata, 32'h12);
      check("addi_dnpc", out_dnpc, 32'h80000004);
      tick();
      exp_cnt++;
      check("addi_cnt", commit_cnt, exp_cnt);
      check("addi_idle", out_valid, 0);

      // stray mem_rvalid while idle
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_rvalid = 1'b0;
      check("stray_rvalid", out_valid, 0);

      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1; in_wb_sel = 3'd3; in_pc_sel = 2'd0; in_ld_fmt = ld_fmt_v[k];
         in_addr_lo = ld_lo_v[k]; in_rd = 5'(k + 8); in_snpc = 32'h1000 + 32'(k);
         tick();
         in_valid = 1'b0; in_addr_lo = 2'd0; in_ld_fmt = 3'd2;
         check("ld_wait_valid", out_valid, 0);
         check("ld_wait_ready", in_ready, 0);
         repeat (2) tick();
         check("ld_wait2_valid", out_valid, 0);
         mem_rvalid = 1'b1; mem_rdata = ld_raw_v[k];
         tick();
         mem_rvalid = 1'b0; mem_rdata = 32'h5A5A5A5A;
         check("ld_valid", out_valid, 1);
         check("ld_wdata", out_wdata, ld_exp_v[k]);
         check("ld_rd", out_rd, 64'(k + 8));
         check("ld_wen", out_wen, 1);
         check("ld_dnpc", out_dnpc, 32'h1000 + 32'(k));
         tick();
         exp_cnt++;
         check("ld_cnt", commit_cnt, exp_cnt);
      end

      // jal under backpressure
      out_ready = 1'b0;
      in_valid = 1'b1; in_wb_sel = 3'd2; in_pc_sel = 2'd1; in_rd = 5'd1;
      in_result = 32'h80000100; in_snpc = 32'h80000008;
      tick();
      in_wb_sel = 3'd1; in_rd = 5'd9; in_result = 32'h77; in_snpc = 32'h99;
      for (int c = 0; c < 4; c++) begin
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_wdata", out_wdata, 32'h80000008);
         check("bp_dnpc", out_dnpc, 32'h80000100);
         check("bp_rd", out_rd, 1);
         tick();
      end
      check("bp_cnt_held", commit_cnt, exp_cnt);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("bp_in_ready_rel", in_ready, 1);
      tick();
      exp_cnt++;
      check("bp_commit_cnt", commit_cnt, exp_cnt);
      check("bp_single", out_valid, 0);

      // back-to-back
      in_valid = 1'b1; in_csr_rdata = '0; in_mtvec = 32'h400;
      for (int i = 0; i < 8; i++) begin
         in_wb_sel = bb_wb_v[i]; in_pc_sel = bb_pc_v[i]; in_rd = 5'(i);
         in_result = 32'h100 + 32'(i); in_snpc = 32'h200 + 32'(4 * i);
         in_csr_rdata = 32'h300 + 32'(i);
         tick();
         check("bb_valid", out_valid, 1);
         check("bb_cnt", commit_cnt, exp_cnt + 64'(i));
         check("bb_rd", out_rd, 64'(i));
         check("bb_wen", out_wen, bb_wen_v[i]);
         check("bb_wdata", out_wdata, bb_wd_v[i]);
         check("bb_dnpc", out_dnpc, bb_dnpc_v[i]);
      end
      in_valid = 1'b0;
      tick();
      exp_cnt += 8;
      check("bb_cnt_final", commit_cnt, exp_cnt);
      check("bb_idle", out_valid, 0);
      check("wrap_cnt", w_commit_cnt, 64'(exp_cnt % 4));

      // ecall
      in_valid = 1'b1; in_wb_sel = 3'd0; in_pc_sel = 2'd2; in_rd = 5'd3;
      in_mtvec = 32'h80000400; in_result = 32'h55; in_snpc = 32'h66;
      tick();
      in_valid = 1'b0;
      check("ecall_wen", out_wen, 0);
      check("ecall_dnpc", out_dnpc, 32'h80000400);
      check("ecall_wdata", out_wdata, 0);
      tick();
      exp_cnt++;
      check("ecall_cnt", commit_cnt, exp_cnt);

      // reset during WAIT_MEM
      in_valid = 1'b1; in_wb_sel = 3'd3; in_ld_fmt = 3'd2; in_rd = 5'd4;
      in_snpc = 32'h80001000; in_pc_sel = 2'd0;
      tick();
      in_valid = 1'b0;
      check("rm_dnpc_pre", out_dnpc, 32'h80001000);
      #2 rst_n = 1'b0;
      #1;
      check("rm_valid", out_valid, 0);
      check("rm_rd", out_rd, 0);
      check("rm_dnpc", out_dnpc, 0);
      check("rm_cnt", commit_cnt, 0);
      check("rm_wrap_cnt", w_commit_cnt, 0);
      tick();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
      tick();
      mem_rvalid = 1'b0;
      check("rm_no_commit", out_valid, 0);
      tick();
      check("rm_no_commit2", out_valid, 0);
      check("rm_cnt_after", commit_cnt, 0);
      check("rm_wdata_after", out_wdata, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
